io_serial_tx: RTL
=================

IO_SERIAL_TX -- requirements
Module: io_serial_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clock cycles per serial bit; legal values are 2..255.
REQ-002 The block SHALL have port CLK  input  1  the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESET  input  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-004 The block SHALL have port TX_DATA  input  8  byte to transmit, driven from I/O port C (data memory address 250).
REQ-005 The block SHALL have port TX_CTRL  input  8  control byte from I/O port D (address 251): bit0 = send toggle, bit1 = overrun clear, bits 7:2 ignored.
REQ-006 The block SHALL have port TXD  output  1  serial line, 8N1 format, LSB first, idle high.
REQ-007 The block SHALL have port STATUS  output  8  to I/O input port B (address 249): bit0 = busy, bit1 = done toggle, bit2 = overrun, bits 7:3 = 0.

Function
REQ-008 Request detection SHALL register TX_CTRL[0] each cycle; a request is any cycle where TX_CTRL[0] differs from its registered value.
REQ-009 The FSM SHALL have states IDLE, START, DATA, STOP; reset state IDLE.
REQ-010 In IDLE, on a request, the block SHALL latch TX_DATA into an 8-bit shift register on that edge and enter START.
REQ-011 TXD SHALL be low from the edge after the request edge; latency request-to-start-bit = 1 cycle.
REQ-012 START, each of the 8 DATA bits, and STOP SHALL each hold TXD for exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-013 DATA SHALL shift LSB first; a 3-bit bit index counts 0..7, and DATA exits to STOP after bit 7 completes.
REQ-014 STOP SHALL drive TXD high; at the end of its last cycle the FSM SHALL return to IDLE and STATUS[1] SHALL invert.
REQ-015 STATUS[0] SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-016 A request while not in IDLE, including the final STOP cycle, SHALL be dropped and SHALL set STATUS[2] sticky.
REQ-017 While TX_CTRL[1]=1, STATUS[2] SHALL clear; if clear and a new overrun occur in the same cycle, the overrun set SHALL win.
REQ-018 A bit-period counter SHALL count 0..CLKS_PER_BIT-1, SHALL reload 0 on each state or bit change, and SHALL NOT run in IDLE.
REQ-019 TX_DATA changes after the request edge SHALL NOT affect the frame in flight.
REQ-020 STATUS and TXD SHALL be driven from registers only, with no combinational path from inputs.

Reset
REQ-021 On RESET=1 the block SHALL set the state to IDLE, TXD=1, STATUS=8'h00, and the bit and period counters to 0.
REQ-022 During reset, the toggle register SHALL load TX_CTRL[0], so the first cycle after reset raises no spurious request.
REQ-023 Reset mid-frame SHALL abort the frame, with TXD high from the next edge and no done toggle.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding (2-bit) and the STATUS bit index constants (BUSY=0, DONE=1, OVR=2).
REQ-025 The bit-period counter SHALL be the sub-module serial_baud_counter, with inputs CLK, RESET, clear and enable, and output tick on count CLKS_PER_BIT-1.

Verification (bench CLKS_PER_BIT=4)
REQ-026 TX_DATA=8'hA5, toggle TX_CTRL[0] 0->1 -> TXD after 1 cycle: 0, then 1,0,1,0,0,1,0,1, then 1; 4 cycles each; STATUS[1] flips after cycle 41.
REQ-027 Second toggle 8 cycles into the frame -> frame unchanged, STATUS=8'h05, STATUS[2] stays 1; TX_CTRL[1]=1 for 1 cycle -> STATUS[2]=0.
REQ-028 RESET asserted in DATA bit 3 -> TXD=1 and STATUS=8'h00 next edge; no frame starts after release with TX_CTRL held.
REQ-029 TX_DATA=8'h00 then 8'hFF sent back-to-back, second toggle in the first IDLE cycle -> two contiguous frames, STATUS[1] toggles twice, no overrun.
REQ-030 TX_DATA changed to 8'h3C during the frame of 8'hC3 -> line shows 8'hC3 bits only.

Source files
------------

// File: rtl/io_serial_tx_pkg.sv
// Shared encodings for the 8N1 serial transmitter: FSM state and STATUS bit positions.
// No logic, so no latency or backpressure of its own.
package io_serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_OVR  = 2;

  localparam logic [2:0] BIT_IDX_LAST = 3'd7;

endpackage

// File: rtl/serial_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled; tick marks the last cycle of a bit.
// Tick is decoded from the count register; clear has priority, no backpressure.
module serial_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  logic [7:0] count;

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/io_serial_tx.sv
// 8N1 serial transmitter driven by a toggle request; start bit appears 1 cycle after the request.
// No backpressure: requests arriving while a frame is in flight are dropped and flagged as overrun.
module io_serial_tx
  import io_serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] TX_DATA,
  input  logic [7:0] TX_CTRL,
  output logic       TXD,
  output logic [7:0] STATUS
);

  tx_state_t  state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       txd_q, txd_d;
  logic       done_q, done_d;
  logic       ovr_q, ovr_d;
  logic       tog_q;
  logic       req, busy, tick;
  logic       unused_ctrl;

  assign req         = TX_CTRL[0] ^ tog_q;
  assign busy        = (state_q != ST_IDLE);
  assign unused_ctrl = ^TX_CTRL[7:2];

  serial_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLK    (CLK),
    .RESET  (RESET),
    .clear  (!busy || tick),
    .enable (busy),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    txd_d     = txd_q;
    done_d    = done_q;
    // A fresh overrun outranks a simultaneous clear.
    ovr_d     = (ovr_q && !TX_CTRL[1]) || (req && busy);

    case (state_q)
      ST_IDLE: begin
        txd_d     = 1'b1;
        bit_idx_d = '0;
        if (req) begin
          state_d = ST_START;
          shreg_d = TX_DATA;
          txd_d   = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          txd_d     = shreg_q[0];
          shreg_d   = {1'b0, shreg_q[7:1]};
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == BIT_IDX_LAST) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shreg_q[0];
            shreg_d   = {1'b0, shreg_q[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
          done_d  = !done_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The toggle register follows TX_CTRL[0] even in reset so release raises no request.
  always_ff @(posedge CLK) begin
    tog_q <= TX_CTRL[0];
    if (RESET) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    STATUS            = '0;
    STATUS[STAT_BUSY] = busy;
    STATUS[STAT_DONE] = done_q;
    STATUS[STAT_OVR]  = ovr_q;
  end

  assign TXD = txd_q;

endmodule
